// File: rtl/word_serial_tx.sv
// Word-serial link transmitter: takes parallel words on a valid/ready handshake and
// shifts them out LSB-first under a frame strobe, with optional even parity and idle gap.
module word_serial_tx #(
   parameter int WIDTH     = 8,
   parameter int PARITY    = 0,
   parameter int IDLE_BITS = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             ser_o,
   output logic             frame_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int GW = (IDLE_BITS > 0) ? $clog2(IDLE_BITS + 1) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [GW-1:0] LAST_GAP = GW'(IDLE_BITS);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_GAP    = 2'd3;

   generate
      if (WIDTH < 1) begin : g_width_check
         $error("word_serial_tx: WIDTH must be at least 1");
      end
   endgenerate

   logic [1:0]       state_reg;
   logic [CW-1:0]    bit_cnt_reg;
   logic [GW-1:0]    gap_cnt_reg;
   logic [WIDTH-1:0] shift_reg;
   logic             par_reg;
   logic             frame_end;

   // Last data bit (no parity) or the parity bit has just been on the line for a cycle.
   always_comb begin
      frame_end = 1'b0;
      if (state_reg == ST_PARITY)
         frame_end = 1'b1;
      else if (state_reg == ST_SHIFT && bit_cnt_reg == LAST_BIT && PARITY == 0)
         frame_end = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg   <= ST_IDLE;
         bit_cnt_reg <= '0;
         gap_cnt_reg <= '0;
         shift_reg   <= '0;
         par_reg     <= 1'b0;
         ready_o     <= 1'b0;
         ser_o       <= 1'b0;
         frame_o     <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               // ready_o is low here only on the first cycle out of reset
               if (!ready_o) begin
                  ready_o <= 1'b1;
               end else if (valid_i) begin
                  shift_reg   <= data_i >> 1;
                  par_reg     <= ^data_i;
                  ser_o       <= data_i[0];
                  frame_o     <= 1'b1;
                  busy_o      <= 1'b1;
                  ready_o     <= 1'b0;
                  bit_cnt_reg <= '0;
                  state_reg   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (bit_cnt_reg != LAST_BIT) begin
                  ser_o       <= shift_reg[0];
                  shift_reg   <= shift_reg >> 1;
                  bit_cnt_reg <= bit_cnt_reg + CW'(1);
               end else if (PARITY != 0) begin
                  ser_o     <= par_reg;
                  state_reg <= ST_PARITY;
               end
            end
            ST_GAP: begin
               if (gap_cnt_reg == LAST_GAP) begin
                  ready_o   <= 1'b1;
                  busy_o    <= 1'b0;
                  state_reg <= ST_IDLE;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + GW'(1);
               end
            end
            default: ;
         endcase

         if (frame_end) begin
            frame_o <= 1'b0;
            ser_o   <= 1'b0;
            done_o  <= 1'b1;
            if (IDLE_BITS == 0) begin
               ready_o   <= 1'b1;
               busy_o    <= 1'b0;
               state_reg <= ST_IDLE;
            end else begin
               gap_cnt_reg <= GW'(1);
               state_reg   <= ST_GAP;
            end
         end
      end
   end

endmodule

// File: tb/tb_word_serial_tx.sv
// Directed bench for word_serial_tx: one instance with parity and a 2-cycle gap,
// one instance with neither, checked cycle by cycle against hand-derived waveforms.
module tb_word_serial_tx;

   logic       clk = 1'b0;
   logic       rst_a, rst_b;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b;
   logic       ready_a, ser_a, frame_a, busy_a, done_a;
   logic       ready_b, ser_b, frame_b, busy_b, done_b;
   logic [4:0] obs_a, obs_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   word_serial_tx #(.WIDTH(8), .PARITY(1), .IDLE_BITS(2)) dut_a (
      .clk_i(clk), .rst_i(rst_a), .data_i(data_a), .valid_i(valid_a),
      .ready_o(ready_a), .ser_o(ser_a), .frame_o(frame_a), .busy_o(busy_a), .done_o(done_a)
   );

   word_serial_tx #(.WIDTH(8), .PARITY(0), .IDLE_BITS(0)) dut_b (
      .clk_i(clk), .rst_i(rst_b), .data_i(data_b), .valid_i(valid_b),
      .ready_o(ready_b), .ser_o(ser_b), .frame_o(frame_b), .busy_o(busy_b), .done_o(done_b)
   );

   // Observation vector order: {ready, busy, frame, ser, done}
   assign obs_a = {ready_a, busy_a, frame_a, ser_a, done_a};
   assign obs_b = {ready_b, busy_b, frame_b, ser_b, done_b};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1;
      valid_a = 1'b1; data_a = 8'h00;
      valid_b = 1'b0; data_b = 8'h00;
      repeat (3) tick();
      checks++;
      if (obs_a !== 5'b00000) begin
         errors++; $display("FAIL reset_hold_a got %b want %b", obs_a, 5'b00000);
      end
      checks++;
      if (obs_b !== 5'b00000) begin
         errors++; $display("FAIL reset_hold_b got %b want %b", obs_b, 5'b00000);
      end
      rst_a = 1'b0; rst_b = 1'b0;
      tick();
      checks++;
      if (obs_a !== 5'b10000) begin
         errors++; $display("FAIL reset_release_a got %b want %b", obs_a, 5'b10000);
      end
      checks++;
      if (obs_b !== 5'b10000) begin
         errors++; $display("FAIL reset_release_b got %b want %b", obs_b, 5'b10000);
      end
      tick();
      checks++;
      if (obs_a !== 5'b01100) begin
         errors++; $display("FAIL reset_first_accept got %b want %b", obs_a, 5'b01100);
      end
      valid_a = 1'b0;
      repeat (11) tick();
      checks++;
      if (obs_a !== 5'b10000) begin
         errors++; $display("FAIL reset_word_recover got %b want %b", obs_a, 5'b10000);
      end
   endtask

   task automatic test_single(input logic [7:0] w, input logic par, input string name);
      logic [8:0] bits;
      bits = {par, w};
      checks++;
      if (obs_a !== 5'b10000) begin
         errors++; $display("FAIL %s_pre got %b want %b", name, obs_a, 5'b10000);
      end
      data_a = w; valid_a = 1'b1;
      tick();
      valid_a = 1'b0; data_a = ~w;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) tick();
         checks++;
         if (obs_a !== {3'b011, bits[k], 1'b0}) begin
            errors++;
            $display("FAIL %s_bit%0d got %b want %b", name, k, obs_a, {3'b011, bits[k], 1'b0});
         end
      end
      tick();
      checks++;
      if (obs_a !== 5'b01001) begin
         errors++; $display("FAIL %s_done got %b want %b", name, obs_a, 5'b01001);
      end
      tick();
      checks++;
      if (obs_a !== 5'b01000) begin
         errors++; $display("FAIL %s_gap got %b want %b", name, obs_a, 5'b01000);
      end
      tick();
      checks++;
      if (obs_a !== 5'b10000) begin
         errors++; $display("FAIL %s_ready got %b want %b", name, obs_a, 5'b10000);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] words [3];
      logic [7:0] w;
      words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
      valid_b = 1'b1;
      for (int f = 0; f < 3; f++) begin
         w = words[f];
         data_b = w;
         tick();
         data_b = 8'h3C;
         for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            checks++;
            if (obs_b !== {3'b011, w[k], 1'b0}) begin
               errors++;
               $display("FAIL b2b_w%0d_bit%0d got %b want %b", f, k, obs_b, {3'b011, w[k], 1'b0});
            end
         end
         tick();
         checks++;
         if (obs_b !== 5'b10001) begin
            errors++; $display("FAIL b2b_w%0d_end got %b want %b", f, obs_b, 5'b10001);
         end
         if (f == 2) valid_b = 1'b0;
      end
      tick();
      checks++;
      if (obs_b !== 5'b10000) begin
         errors++; $display("FAIL b2b_idle got %b want %b", obs_b, 5'b10000);
      end
   endtask

   task automatic test_valid_while_busy();
      logic [8:0] bits;
      bits = {1'b0, 8'h96};
      data_a = 8'h96; valid_a = 1'b1;
      tick();
      data_a = 8'h3C;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) tick();
         checks++;
         if (obs_a !== {3'b011, bits[k], 1'b0}) begin
            errors++;
            $display("FAIL busy_first_bit%0d got %b want %b", k, obs_a, {3'b011, bits[k], 1'b0});
         end
      end
      tick();
      checks++;
      if (obs_a !== 5'b01001) begin
         errors++; $display("FAIL busy_first_done got %b want %b", obs_a, 5'b01001);
      end
      tick();
      checks++;
      if (obs_a !== 5'b01000) begin
         errors++; $display("FAIL busy_no_accept got %b want %b", obs_a, 5'b01000);
      end
      tick();
      checks++;
      if (obs_a !== 5'b10000) begin
         errors++; $display("FAIL busy_ready got %b want %b", obs_a, 5'b10000);
      end
      bits = {1'b0, 8'h3C};
      tick();
      valid_a = 1'b0;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) tick();
         checks++;
         if (obs_a !== {3'b011, bits[k], 1'b0}) begin
            errors++;
            $display("FAIL busy_second_bit%0d got %b want %b", k, obs_a, {3'b011, bits[k], 1'b0});
         end
      end
      repeat (3) tick();
      checks++;
      if (obs_a !== 5'b10000) begin
         errors++; $display("FAIL busy_second_ready got %b want %b", obs_a, 5'b10000);
      end
   endtask

   task automatic test_async_reset();
      data_a = 8'hA5; valid_a = 1'b1;
      tick();
      valid_a = 1'b0;
      repeat (4) tick();
      checks++;
      if (obs_a !== 5'b01100) begin
         errors++; $display("FAIL areset_bit4 got %b want %b", obs_a, 5'b01100);
      end
      #2 rst_a = 1'b1;
      #1;
      checks++;
      if (obs_a !== 5'b00000) begin
         errors++; $display("FAIL areset_immediate got %b want %b", obs_a, 5'b00000);
      end
      tick();
      checks++;
      if (obs_a !== 5'b00000) begin
         errors++; $display("FAIL areset_held got %b want %b", obs_a, 5'b00000);
      end
      rst_a = 1'b0;
      tick();
      checks++;
      if (obs_a !== 5'b10000) begin
         errors++; $display("FAIL areset_release got %b want %b", obs_a, 5'b10000);
      end
      test_single(8'h5A, 1'b0, "after_reset_5a");
   endtask

   initial begin
      test_reset();
      test_single(8'hA5, 1'b0, "single_a5");
      test_single(8'h07, 1'b1, "single_07");
      test_back_to_back();
      test_valid_while_busy();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
